riscv_decode_stage: RTL
=======================

Name: riscv_decode_stage

Overview:
Registered RV32I/RV64I decode stage that sits between fetch and register-read/execute. It accepts a 32-bit instruction plus its PC over a valid/ready handshake and classifies the instruction format. It selects and sign-extends the single applicable immediate to XLEN, flags illegal encodings, and emits register-use hints. The stage is generalised over XLEN and adds pipelining, back-pressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Governs immediate and PC width and RV64-only legality.
RST_PC_OUT, 0, value driven on out_pc while reset is asserted.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held instructions
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts the bundle
out_pc  output  XLEN  PC passed through
out_opcode  output  7  instr[6:0]
out_rd / out_rs1 / out_rs2  output  5 each  register fields
out_funct3  output  3  instr[14:12]
out_funct7  output  7  instr[31:25]
out_fmt  output  3  format code: R, I, S, B, U, J, ILL
out_imm  output  XLEN  selected immediate, sign-extended
out_illegal  output  1  unsupported or illegal encoding
out_uses_rs1 / out_uses_rs2 / out_writes_rd  output  1 each  hazard hints

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0; all data outputs=0 (out_pc=RST_PC_OUT); skid buffer empty. in_ready=1 after release.
- Latency: one cycle. A transfer occurs when in_valid && in_ready. The bundle appears on out_valid the next edge and holds stable until out_valid && out_ready.
- Without the skid buffer: in_ready = !out_valid || out_ready. This path is combinational from out_ready.
- Format by opcode:
  - 0110111 / 0010111: U.
  - 1101111: J.
  - 1100111: I; funct3 != 000 is illegal.
  - 1100011: B; funct3 010/011 is illegal.
  - 0000011: I; funct3 111 is illegal; 011 and 110 are legal only when XLEN=64.
  - 0100011: S; funct3 >= 100 is illegal; 011 is legal only when XLEN=64.
  - 0010011, 0001111, 1110011: I.
  - 0110011: R.
  - 0011011 (I) and 0111011 (R): legal only when XLEN=64.
  - Any other opcode, or instr[1:0] != 11: illegal.
- Immediate extraction per RISC-V base ISA. I/S/B/J immediates are sign-extended from instr[31] to XLEN. U is {instr[31:12], 12'b0}, sign-extended to XLEN. R gives 0.
- Illegal instruction: out_fmt=ILL, out_illegal=1, out_imm=0, all hint bits=0. Fields are still passed raw.
- Hint bits:
  - out_uses_rs1 = fmt in {R, I, S, B}.
  - out_uses_rs2 = fmt in {R, S, B}.
  - out_writes_rd = fmt in {R, I, U, J} && rd != 0; forced 0 for 0001111 (fence).
- Flush: on the next edge out_valid=0 and the skid buffer is cleared. An input presented in the same cycle as flush is dropped (in_ready may read 1, but nothing is captured). Flush has priority over out_ready.
- Stall: while out_valid && !out_ready, output registers hold. No instruction is lost or reordered.
- Reset mid-operation discards all state immediately, with no partial bundle.

Optional Feature:
RISCV_DEC_SKID_EN
- Defined: adds a one-entry skid register. in_ready is registered (in_ready = skid empty) with no combinational path from out_ready. Full throughput is sustained. At most one extra instruction is buffered during a stall, and it is drained in order ahead of new input.
- Undefined: no skid register; in_ready as stated in Behaviour.
- Cycle latency is 1 in both cases.

Decomposition:
- Package riscv_dec_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM, OP_IMM32, OP_REG32);
  - format enum FMT_R..FMT_ILL as 3-bit constants.
- Sub-module riscv_imm_gen: combinational. Takes instr and fmt, produces the XLEN-wide immediate. It is shared later by the compressed-expansion work.

Test Plan:
- XLEN=32, send 0xFFF10093 (addi x1,x2,-1), out_ready=1: next cycle out_valid=1, rd=1, rs1=2, fmt=I, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0.
- Send 0xFE000EE3 (beq x0,x0,-4): fmt=B, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC), uses_rs1=uses_rs2=1, writes_rd=0.
- Send 0x00000000, and 0x00003003 (ld) at XLEN=32: both give out_illegal=1, fmt=ILL, imm=0. At XLEN=64, 0x00003003 is legal with fmt=I.
- Back-to-back stream of 0x00100093, 0x00200113, 0x00300193 with out_ready low for 3 cycles mid-stream: all three emerge in order exactly once. in_ready drops during the stall.
- flush asserted during a stall with the skid buffer occupied: out_valid=0 next cycle, and the buffered instruction is never emitted.
- rst_n pulled low for 1 cycle asynchronously while out_valid=1: out_valid=0 immediately, out_pc=RST_PC_OUT, and normal operation resumes after release.

Source files
------------

// File: rtl/riscv_dec_pkg.sv
// Shared decode definitions: opcode constants, format codes and the
// format/legality/hint classification used by the decode stage.
package riscv_dec_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  // Everything about a decoded instruction that does not depend on XLEN.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
  } dec_info_t;

  function automatic fmt_e classify(input logic [31:0] instr, input logic rv64);
    logic [2:0] f3;
    fmt_e       fmt;
    f3  = instr[14:12];
    fmt = FMT_ILL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_LUI, OP_AUIPC: fmt = FMT_U;
        OP_JAL:           fmt = FMT_J;
        OP_JALR: begin
          if (f3 == 3'b000) fmt = FMT_I;
        end
        OP_BRANCH: begin
          if (f3[2:1] != 2'b01) fmt = FMT_B;
        end
        OP_LOAD: begin
          // ld (011) and lwu (110) only exist on RV64
          if (f3 != 3'b111 && (rv64 || (f3 != 3'b011 && f3 != 3'b110))) fmt = FMT_I;
        end
        OP_STORE: begin
          if (!f3[2] && (rv64 || f3 != 3'b011)) fmt = FMT_S;
        end
        OP_IMM, OP_FENCE, OP_SYSTEM: fmt = FMT_I;
        OP_REG:                      fmt = FMT_R;
        OP_IMM32: begin
          if (rv64) fmt = FMT_I;
        end
        OP_REG32: begin
          if (rv64) fmt = FMT_R;
        end
        default: fmt = FMT_ILL;
      endcase
    end
    return fmt;
  endfunction

  function automatic dec_info_t decode_info(input logic [31:0] instr, input logic rv64);
    dec_info_t info;
    info.opcode    = instr[6:0];
    info.rd        = instr[11:7];
    info.rs1       = instr[19:15];
    info.rs2       = instr[24:20];
    info.funct3    = instr[14:12];
    info.funct7    = instr[31:25];
    info.fmt       = classify(instr, rv64);
    info.illegal   = (info.fmt == FMT_ILL);
    info.uses_rs1  = info.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    info.uses_rs2  = info.fmt inside {FMT_R, FMT_S, FMT_B};
    // fence encodes ordering bits in rd, it never writes a register
    info.writes_rd = (info.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                     (instr[11:7] != 5'd0) && (instr[6:0] != OP_FENCE);
    return info;
  endfunction

endpackage

// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The stage uses the slave view; the surrounding pipeline uses master.
interface riscv_decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic            out_uses_rs1;
  logic            out_uses_rs2;
  logic            out_writes_rd;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_fmt, out_imm, out_illegal,
           out_uses_rs1, out_uses_rs2, out_writes_rd
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_fmt, out_imm, out_illegal,
           out_uses_rs1, out_uses_rs2, out_writes_rd
  );
endinterface

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: picks the immediate implied by the
// instruction format and sign-extends it to XLEN (zero for R and illegal).
module riscv_imm_gen
  import riscv_dec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  fmt_e            fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr_i[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt_i)
      FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      FMT_U: imm32 = {instr_i[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // imm32 is already sign-correct, so widening sign-extends from instr[31]
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshake and flush.
// Define RISCV_DEC_SKID_EN to add a one-entry skid buffer and register in_ready.
module riscv_decode_stage
  import riscv_dec_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RST_PC_OUT = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 flush,
  riscv_decode_stage_if.slave dec
);

  dec_info_t       in_info;
  logic [XLEN-1:0] in_imm;
  logic            in_ready;
  logic            accept;
  logic            out_free;

  logic            out_valid_q, out_valid_d;
  dec_info_t       out_info_q, out_info_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;

  assign in_info = decode_info(dec.in_instr, XLEN == 64);

  riscv_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr_i(dec.in_instr),
    .fmt_i  (in_info.fmt),
    .imm_o  (in_imm)
  );

  assign out_free = !out_valid_q || dec.out_ready;
  // A flushed cycle never captures, even if in_ready reads high
  assign accept   = dec.in_valid && in_ready && !flush;

`ifdef RISCV_DEC_SKID_EN
  logic            skid_valid_q, skid_valid_d;
  dec_info_t       skid_info_q, skid_info_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;

  assign in_ready = !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_info_d   = out_info_q;
    out_pc_d     = out_pc_q;
    out_imm_d    = out_imm_q;
    skid_valid_d = skid_valid_q;
    skid_info_d  = skid_info_q;
    skid_pc_d    = skid_pc_q;
    skid_imm_d   = skid_imm_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Buffered entry goes first; in_ready was low so nothing new arrives
        out_valid_d  = 1'b1;
        out_info_d   = skid_info_q;
        out_pc_d     = skid_pc_q;
        out_imm_d    = skid_imm_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_info_d = in_info;
          out_pc_d   = dec.in_pc;
          out_imm_d  = in_imm;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_info_d  = in_info;
      skid_pc_d    = dec.in_pc;
      skid_imm_d   = in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_info_q  <= '0;
      skid_pc_q    <= '0;
      skid_imm_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_info_q  <= skid_info_d;
      skid_pc_q    <= skid_pc_d;
      skid_imm_q   <= skid_imm_d;
    end
  end
`else
  assign in_ready = out_free;

  always_comb begin
    out_valid_d = out_valid_q;
    out_info_d  = out_info_q;
    out_pc_d    = out_pc_q;
    out_imm_d   = out_imm_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_free) begin
      out_valid_d = accept;
      if (accept) begin
        out_info_d = in_info;
        out_pc_d   = dec.in_pc;
        out_imm_d  = in_imm;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_info_q  <= '0;
      out_pc_q    <= RST_PC_OUT;
      out_imm_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_info_q  <= out_info_d;
      out_pc_q    <= out_pc_d;
      out_imm_q   <= out_imm_d;
    end
  end

  assign dec.in_ready      = in_ready;
  assign dec.out_valid     = out_valid_q;
  assign dec.out_pc        = out_pc_q;
  assign dec.out_opcode    = out_info_q.opcode;
  assign dec.out_rd        = out_info_q.rd;
  assign dec.out_rs1       = out_info_q.rs1;
  assign dec.out_rs2       = out_info_q.rs2;
  assign dec.out_funct3    = out_info_q.funct3;
  assign dec.out_funct7    = out_info_q.funct7;
  assign dec.out_fmt       = out_info_q.fmt;
  assign dec.out_imm       = out_imm_q;
  assign dec.out_illegal   = out_info_q.illegal;
  assign dec.out_uses_rs1  = out_info_q.uses_rs1;
  assign dec.out_uses_rs2  = out_info_q.uses_rs2;
  assign dec.out_writes_rd = out_info_q.writes_rd;

endmodule
